// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single 4-bit slice, carry held in a register.
// Optional: define SERIAL_NIBBLE_ADDER_SUB_EN for the sub input (a - b - cin) and the ovf output.
module nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module serial_nibble_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
  input  logic                   sub,
  output logic                   ovf,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   cout,
  output logic                   busy
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;

  logic [W-1:0]  a_reg, b_reg;
  logic [IW-1:0] idx;
  logic          carry;
  logic          accept, last;
  logic [3:0]    sl_a, sl_b, sl_s;
  logic          sl_c;
  logic          sub_en;

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (idx == IW'(NIBBLES-1));
  assign sl_a   = a_reg[4*idx +: 4];
  assign sl_b   = b_reg[4*idx +: 4];

  nibble_add u_slice (.a(sl_a), .b(sl_b), .cin(carry), .s(sl_s), .cout(sl_c));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Subtraction is a + ~b + ~cin, folded into the operand latch so the slice only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg <= a;
          b_reg <= sub_en ? ~b : b;
          carry <= cin ^ sub_en;
          idx   <= '0;
        end
        RUN: begin
          s[4*idx +: 4] <= sl_s;
          carry         <= sl_c;
          idx           <= idx + IW'(1);
          if (last) cout <= sl_c;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
  // Carry into the MSB is recovered from the top slice's sum bit: c3 = a3 ^ b3 ^ s3.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (state == RUN && last) ovf <= sl_c ^ (sl_a[3] ^ sl_b[3] ^ sl_s[3]);
`endif
endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder (NIBBLES=4); expected {cout,s} queued at the accept edge.
module tb_serial_nibble_adder;
  localparam int N = 4;
  localparam int W = 4*N;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cout, busy;
  logic [W-1:0] a = '0, b = '0, s;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_nibble_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
    .sub(sub), .ovf(ovf),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .busy(busy)
  );

  // Present one op, check latency and result against the scoreboard, then optionally stall before handshake.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic tsub, input bit pre_ready, input int hold);
    exp_t e, g;
    logic [W-1:0] bb;
    logic [W:0]   full;
    int lat, w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_wait got %b want 1", in_ready); end
    bb   = tsub ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, tc ^ tsub};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = (ta[W-1] == bb[W-1]) && (e.s[W-1] != ta[W-1]);
    exp_q.push_back(e);
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = tsub;
    out_ready = pre_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL run_flags busy=%b in_ready=%b want 1/0", busy, in_ready);
      end
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != N) begin errors++; $display("FAIL latency got %0d want %0d edges after accept", lat, N); end
    g = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || s !== g.s || cout !== g.c) begin
      errors++;
      $display("FAIL result a=%h b=%h got v=%b s=%h c=%b want v=1 s=%h c=%b", ta, tb_, out_valid, s, cout, g.s, g.c);
    end
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
    checks++;
    if (ovf !== g.v) begin errors++; $display("FAIL ovf got %b want %b", ovf, g.v); end
`endif
    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || s !== g.s || cout !== g.c || in_ready !== 1'b0) begin
          errors++; $display("FAIL hold v=%b s=%h c=%b rdy=%b want 1 %h %b 0", out_valid, s, cout, in_ready, g.s, g.c);
        end
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL handshake v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== '0 || cout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold rdy=%b v=%b s=%h c=%b busy=%b", in_ready, out_valid, s, cout, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== '0 || cout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release rdy=%b v=%b s=%h c=%b busy=%b", in_ready, out_valid, s, cout, busy);
    end
  endtask

  task automatic test_add();
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_carry();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    fork
      run_op(16'h00A5, 16'h005A, 1'b0, 1'b0, 1'b0, 10);
      begin
        // Stray operands while the result is held must be dropped.
        repeat (9) @(negedge clk);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
        @(negedge clk); in_valid = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL ignored_op v=%b busy=%b q=%0d want 0 0 0", out_valid, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1357; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== '0 || cout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset rdy=%b v=%b s=%h c=%b busy=%b", in_ready, out_valid, s, cout, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL no_pulse_after_reset v=%b want 0", out_valid); end
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1, 0);
  endtask

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
  task automatic test_sub();
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'h0009, 16'h0003, 1'b1, 1'b1, 1'b1, 0);
  endtask
`endif

  initial begin
    fork
      begin
        test_reset();
        test_add();
        test_carry();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
        test_sub();
`endif
      end
      begin
        #200000;
        errors++;
        $display("FAIL timeout");
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
